// File: rtl/mvm_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// mvm_host_ctrl_if
// Bundles the host command/operand/result streams and the engine
// load/start/done streaming signals used by mvm_host_ctrl.
//
//   Host side : cmd_valid/cmd_op/cmd_ready, wr_data/wr_valid/wr_ready,
//               res_data/res_valid/res_last/res_ready, busy, timeout_err
//   Engine    : loadMatrix, loadVector, start, data_in (to engine),
//               done, data_out (from engine)
//
// master : the controller (mvm_host_ctrl)
// slave  : the host plus engine that surround it
// -----------------------------------------------------------------------------
interface mvm_host_ctrl_if #(
  parameter int T  = 8,
  parameter int OW = 2*T
);
  // host command stream
  logic                 cmd_valid;
  logic [1:0]           cmd_op;
  logic                 cmd_ready;
  // host operand stream
  logic signed [T-1:0]  wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  // engine control / operand path
  logic                 loadMatrix;
  logic                 loadVector;
  logic                 start;
  logic                 done;
  logic signed [T-1:0]  data_in;
  logic signed [OW-1:0] data_out;
  // host result stream
  logic signed [OW-1:0] res_data;
  logic                 res_valid;
  logic                 res_last;
  logic                 res_ready;
  // status
  logic                 busy;
  logic                 timeout_err;

  modport master (
    input  cmd_valid, cmd_op, wr_data, wr_valid, done, data_out, res_ready,
    output cmd_ready, wr_ready, loadMatrix, loadVector, start, data_in,
           res_data, res_valid, res_last, busy, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_op, wr_data, wr_valid, done, data_out, res_ready,
    input  cmd_ready, wr_ready, loadMatrix, loadVector, start, data_in,
           res_data, res_valid, res_last, busy, timeout_err
  );
endinterface

// File: rtl/mvm_host_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_host_ctrl
// Host-side initiator for the matrix-vector multiply engine. Accepts one host
// command at a time (load matrix, load vector, start), buffers operand words
// so each load reaches the engine as one unbroken burst right after its
// load pulse, captures the M result words that follow done, and returns them
// to the host on a valid/ready stream with a last marker.
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : mvm_host_ctrl_if.master (host command/operand/result streams,
//           engine load/start/done/data signals, busy and timeout_err)
//
// Parameters
//   M       : matrix dimension (M*M matrix, M-element vector)
//   T       : operand width, signed
//   OW      : result width, signed (passed through bit-exact)
//   TIMEOUT : cycles from the start pulse to giving up on done (>= 2)
// -----------------------------------------------------------------------------
module mvm_host_ctrl #(
  parameter int M       = 4,
  parameter int T       = 8,
  parameter int OW      = 2*T,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  mvm_host_ctrl_if.master bus
);

  localparam int N_MAT = M * M;
  localparam int CW    = (N_MAT > 1) ? $clog2(N_MAT) : 1;
  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_MAT = CW'(N_MAT - 1);
  localparam logic [CW-1:0] LAST_VEC = CW'(M - 1);
  // The start cycle counts as cycle 0 and WAIT_DONE is entered with the
  // timer at 0, so the error must be raised on the edge that ends cycle
  // TIMEOUT-1 for it to be visible exactly TIMEOUT cycles after the pulse.
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_START   = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_CAPTURE = 3'd6;
  localparam logic [2:0] S_DRAIN   = 3'd7;

  // control state
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_is_mat;
  logic          r_live;
  logic          r_timeout_err;

  // operand and result storage (contents are don't-care after reset)
  logic signed [T-1:0]  r_buf  [N_MAT];
  logic signed [OW-1:0] r_rbuf [M];

  logic          w_cmd_fire;
  logic          w_wr_fire;
  logic [CW-1:0] w_last_idx;
  logic          w_cnt_last_m;

  // r_live keeps cmd_ready low while reset is held and during the first
  // cycle after release, so every output reads 0 in reset.
  assign w_cmd_fire   = bus.cmd_valid && r_live && (r_state == S_IDLE);
  assign w_wr_fire    = bus.wr_valid && (r_state == S_FILL);
  assign w_last_idx   = r_is_mat ? LAST_MAT : LAST_VEC;
  assign w_cnt_last_m = (r_cnt == LAST_VEC);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_is_mat      <= 1'b0;
      r_live        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            case (bus.cmd_op)
              2'd0: begin
                r_is_mat <= 1'b1;
                r_cnt    <= '0;
                r_state  <= S_FILL;
              end
              2'd1: begin
                r_is_mat <= 1'b0;
                r_cnt    <= '0;
                r_state  <= S_FILL;
              end
              2'd2: begin
                r_state <= S_START;
              end
              default: begin
                // reserved op: handshake completes, nothing happens
              end
            endcase
          end
        end

        S_FILL: begin
          if (w_wr_fire) begin
            if (r_cnt == w_last_idx) begin
              r_cnt   <= '0;
              r_state <= S_PULSE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_PULSE: begin
          r_state <= S_STREAM;
        end

        S_STREAM: begin
          if (r_cnt == w_last_idx) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.done) begin
            r_cnt   <= '0;
            r_state <= S_CAPTURE;
          end else if (r_timer == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        // The engine streams one result per cycle after done with no way to
        // pause it, so capture never waits on the host.
        S_CAPTURE: begin
          if (w_cnt_last_m) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (bus.res_ready) begin
            if (w_cnt_last_m) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand / result storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_buf[r_cnt] <= bus.wr_data;
    end
    if (r_state == S_CAPTURE) begin
      r_rbuf[r_cnt[RW-1:0]] <= bus.data_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from state so an async reset clears them immediately
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready   = r_live && (r_state == S_IDLE);
  assign bus.wr_ready    = (r_state == S_FILL);
  assign bus.loadMatrix  = (r_state == S_PULSE) &&  r_is_mat;
  assign bus.loadVector  = (r_state == S_PULSE) && !r_is_mat;
  assign bus.start       = (r_state == S_START);
  assign bus.data_in     = (r_state == S_STREAM) ? r_buf[r_cnt] : '0;
  assign bus.res_valid   = (r_state == S_DRAIN);
  assign bus.res_data    = (r_state == S_DRAIN) ? r_rbuf[r_cnt[RW-1:0]] : '0;
  assign bus.res_last    = (r_state == S_DRAIN) && w_cnt_last_m;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mvm_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mvm_host_ctrl
// Directed bench for mvm_host_ctrl (M=4, T=8, OW=16) with a behavioural
// engine that latches the streamed operands, computes A*x on start and
// replies with done followed by M result words.
// -----------------------------------------------------------------------------
module tb_mvm_host_ctrl;

  localparam int M  = 4;
  localparam int T  = 8;
  localparam int OW = 16;
  localparam int TO = 1024;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  int wq[16];
  int exp_res[4];
  int eng_a[16];
  int eng_x[4];
  logic stub_no_done;

  mvm_host_ctrl_if #(.T(T), .OW(OW)) h ();

  mvm_host_ctrl #(.M(M), .T(T), .OW(OW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (h)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // behavioural engine, sampling on the falling edge
  initial begin : engine
    int st;
    int ec;
    int y[4];
    st = 0;
    ec = 0;
    h.done     = 1'b0;
    h.data_out = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        st = 0;
        ec = 0;
      end else if (st == 1) begin
        eng_a[ec] = int'(h.data_in);
        ec++;
        if (ec == M*M) st = 0;
      end else if (st == 2) begin
        eng_x[ec] = int'(h.data_in);
        ec++;
        if (ec == M) st = 0;
      end else if (h.loadMatrix) begin
        st = 1;
        ec = 0;
      end else if (h.loadVector) begin
        st = 2;
        ec = 0;
      end else if (h.start && !stub_no_done) begin
        for (int i = 0; i < M; i++) begin
          y[i] = 0;
          for (int j = 0; j < M; j++) y[i] += eng_a[i*M+j] * eng_x[j];
        end
        repeat (2) @(negedge clk);
        h.done = 1'b1;
        @(negedge clk);
        h.done = 1'b0;
        for (int i = 0; i < M; i++) begin
          h.data_out = OW'(y[i]);
          @(negedge clk);
        end
        h.data_out = '0;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op);
    int t;
    t = 0;
    @(negedge clk);
    h.cmd_valid = 1'b1;
    h.cmd_op    = op;
    while (!h.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!h.cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    h.cmd_valid = 1'b0;
  endtask

  task automatic write_words(input int n, input int stall_at, input int stall_len);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        h.wr_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      h.wr_valid = 1'b1;
      h.wr_data  = T'(wq[i]);
      t = 0;
      while (!h.wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!h.wr_ready) check("wr_accept_timeout", 0, 1);
      @(negedge clk);
    end
    h.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!h.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!h.cmd_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic load(input logic [1:0] op, input int n);
    send_cmd(op);
    write_words(n, -1, 0);
    wait_idle();
  endtask

  task automatic drain(input int stall_at, input int stall_len);
    int k;
    int s;
    int t;
    k = 0;
    s = stall_len;
    t = 0;
    while (k < M && t < 200) begin
      t++;
      if (h.res_valid) begin
        check("drain_cmd_ready_low", int'(h.cmd_ready), 0);
        check("res_data", int'(h.res_data), exp_res[k]);
        if (k == stall_at && s > 0) begin
          h.res_ready = 1'b0;
          s--;
        end else begin
          check("res_last", int'(h.res_last), (k == M-1) ? 1 : 0);
          h.res_ready = 1'b1;
          k++;
        end
      end
      @(negedge clk);
    end
    h.res_ready = 1'b0;
    if (k < M) check("drain_timeout", k, M);
    check("res_valid_after_drain", int'(h.res_valid), 0);
    check("cmd_ready_after_drain", int'(h.cmd_ready), 1);
  endtask

  task automatic run_start(input int stall_at, input int stall_len);
    int t;
    t = 0;
    send_cmd(2'd2);
    while (!h.res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!h.res_valid) check("res_valid_timeout", 0, 1);
    else drain(stall_at, stall_len);
  endtask

  initial begin : main
    int t;
    int saw_res;
    n_checks     = 0;
    n_fail       = 0;
    stub_no_done = 1'b0;
    reset        = 1'b0;
    h.cmd_valid  = 1'b0;
    h.cmd_op     = 2'd0;
    h.wr_valid   = 1'b0;
    h.wr_data    = '0;
    h.res_ready  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(h.cmd_ready), 0);
    check("rst_busy", int'(h.busy), 0);
    check("rst_timeout_err", int'(h.timeout_err), 0);
    check("rst_res_valid", int'(h.res_valid), 0);
    check("rst_data_in", int'(h.data_in), 0);
    reset = 1'b1;
    #1;
    check("cmd_ready_before_edge", int'(h.cmd_ready), 0);
    @(negedge clk);
    check("cmd_ready_after_edge", int'(h.cmd_ready), 1);

    // load matrix 1..16 with a 3-cycle host stall after word 5
    for (int i = 0; i < 16; i++) wq[i] = i + 1;
    send_cmd(2'd0);
    write_words(16, 5, 3);
    t = 0;
    while (!h.loadMatrix && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lm_pulse_high", int'(h.loadMatrix), 1);
    check("lm_pulse_data_in", int'(h.data_in), 0);
    check("lm_pulse_no_lv", int'(h.loadVector), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("lm_pulse_low", int'(h.loadMatrix), 0);
      check("lm_stream", int'(h.data_in), i + 1);
    end
    @(negedge clk);
    check("lm_cmd_ready_back", int'(h.cmd_ready), 1);
    check("lm_data_in_idle", int'(h.data_in), 0);

    // identity matrix, vector [1,-2,3,-4]
    for (int i = 0; i < 16; i++) wq[i] = (i % 5 == 0) ? 1 : 0;
    load(2'd0, 16);
    wq[0] = 1; wq[1] = -2; wq[2] = 3; wq[3] = -4;
    load(2'd1, 4);
    exp_res = '{1, -2, 3, -4};
    run_start(-1, 0);

    // all-7 matrix, two vector loads, backpressure of 5 cycles on word 2
    for (int i = 0; i < 16; i++) wq[i] = 7;
    load(2'd0, 16);
    wq[0] = -11; wq[1] = 11; wq[2] = -11; wq[3] = 11;
    load(2'd1, 4);
    for (int i = 0; i < 4; i++) wq[i] = 11;
    load(2'd1, 4);
    exp_res = '{308, 308, 308, 308};
    run_start(2, 5);

    // reserved op is accepted and discarded
    send_cmd(2'd3);
    check("op3_busy", int'(h.busy), 0);
    check("op3_cmd_ready", int'(h.cmd_ready), 1);

    // timeout with engine never raising done
    stub_no_done = 1'b1;
    saw_res = 0;
    send_cmd(2'd2);
    check("to_start_pulse", int'(h.start), 1);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (h.res_valid) saw_res = 1;
      if (c == 1) check("to_start_one_cycle", int'(h.start), 0);
      if (c == TO - 1) check("to_err_early", int'(h.timeout_err), 0);
      if (c == TO) begin
        check("to_err_set", int'(h.timeout_err), 1);
        check("to_idle_busy", int'(h.busy), 0);
        check("to_idle_cmd_ready", int'(h.cmd_ready), 1);
      end
    end
    check("to_no_res_valid", saw_res, 0);
    @(negedge clk);
    check("to_err_sticky", int'(h.timeout_err), 1);
    stub_no_done = 1'b0;

    // reset in the middle of a matrix stream at word 6
    for (int i = 0; i < 16; i++) wq[i] = i + 1;
    send_cmd(2'd0);
    write_words(16, -1, 0);
    t = 0;
    while (int'(h.data_in) != 6 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("mid_stream_word6", int'(h.data_in), 6);
    reset = 1'b0;
    #1;
    check("abort_data_in", int'(h.data_in), 0);
    check("abort_loadMatrix", int'(h.loadMatrix), 0);
    check("abort_busy", int'(h.busy), 0);
    check("abort_cmd_ready", int'(h.cmd_ready), 0);
    check("abort_err_cleared", int'(h.timeout_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", int'(h.cmd_ready), 1);
    load(2'd0, 16);
    for (int i = 0; i < 4; i++) wq[i] = 1;
    load(2'd1, 4);
    exp_res = '{10, 26, 42, 58};
    run_start(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
